// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage
//  Description : Quinta pipeline data-memory stage. RV32I loads/stores against
//                an internal word-organised synchronous RAM, with bubble and
//                stall handling. One-cycle latency to the write-back stage.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_stage #(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] alu_res,
    input  logic [31:0] store_data,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd_in,
    input  logic        reg_write_in,
    input  logic        bubble_in,
    input  logic        stall,
    output logic [31:0] wb_data,
    output logic [4:0]  rd_out,
    output logic        reg_write_out,
    output logic        valid_out,
    output logic        misaligned
);

    // Access size encoded in funct3[1:0]; funct3[2] selects zero-extension.
    localparam logic [1:0] c_SZ_BYTE = 2'b00;
    localparam logic [1:0] c_SZ_HALF = 2'b01;

    localparam logic [2:0] c_F3_LB  = 3'b000;
    localparam logic [2:0] c_F3_LH  = 3'b001;
    localparam logic [2:0] c_F3_LBU = 3'b100;
    localparam logic [2:0] c_F3_LHU = 3'b101;

    logic [31:0]       r_mem [DEPTH_WORDS];
    logic [31:0]       r_rdata;
    logic [31:0]       r_alu_res;
    logic [2:0]        r_funct3;
    logic              r_is_load;

    logic [ADDR_W-1:0] w_idx;
    logic [1:0]        w_off;
    logic              w_mis_pat;
    logic              w_mis;
    logic              w_ram_en;
    logic              w_do_write;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic [31:0]       w_shift;
    logic [31:0]       w_load;

    assign w_idx = alu_res[ADDR_W+1:2];
    assign w_off = alu_res[1:0];

    // RAM port is active only outside reset and stall; a memory op also
    // needs a live (non-bubble) slot and an aligned address to write.
    assign w_ram_en   = !rst && !stall;
    assign w_mis      = w_mis_pat && (mem_read || mem_write);
    assign w_do_write = w_ram_en && !bubble_in && mem_write && !w_mis;

    // Alignment check by access size; byte accesses are always aligned.
    always_comb begin
        w_mis_pat = 1'b0;
        case (funct3[1:0])
            c_SZ_BYTE: w_mis_pat = 1'b0;
            c_SZ_HALF: w_mis_pat = alu_res[0];
            default:   w_mis_pat = |alu_res[1:0];
        endcase
    end

    // Byte-lane enables and lane-replicated store data.
    always_comb begin
        w_be    = 4'hF;
        w_wdata = store_data;
        case (funct3[1:0])
            c_SZ_BYTE: begin
                w_be    = 4'b0001 << w_off;
                w_wdata = {4{store_data[7:0]}};
            end
            c_SZ_HALF: begin
                w_be    = 4'b0011 << w_off;
                w_wdata = {2{store_data[15:0]}};
            end
            default: begin
                w_be    = 4'hF;
                w_wdata = store_data;
            end
        endcase
    end

    // Synchronous RAM: byte-masked write and registered read, both frozen by stall.
    always_ff @(posedge clk) begin
        if (w_ram_en) begin
            for (int i = 0; i < 4; i++) begin
                if (w_do_write && w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
            r_rdata <= r_mem[w_idx];
        end
    end

    // Pipeline register toward write-back; a bubble becomes a no-op slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alu_res     <= 32'd0;
            r_funct3      <= 3'd0;
            r_is_load     <= 1'b0;
            rd_out        <= 5'd0;
            reg_write_out <= 1'b0;
            valid_out     <= 1'b0;
            misaligned    <= 1'b0;
        end else if (!stall) begin
            r_alu_res     <= alu_res;
            r_funct3      <= funct3;
            r_is_load     <= mem_read && !mem_write && !bubble_in;
            rd_out        <= bubble_in ? 5'd0 : rd_in;
            reg_write_out <= reg_write_in && !bubble_in && !w_mis;
            valid_out     <= !bubble_in;
            misaligned    <= w_mis && !bubble_in;
        end
    end

    // Load formatting: shift the addressed lane down, then extend by funct3.
    always_comb begin
        w_shift = r_rdata >> {r_alu_res[1:0], 3'b000};
        case (r_funct3)
            c_F3_LB:  w_load = {{24{w_shift[7]}}, w_shift[7:0]};
            c_F3_LH:  w_load = {{16{w_shift[15]}}, w_shift[15:0]};
            c_F3_LBU: w_load = {24'd0, w_shift[7:0]};
            c_F3_LHU: w_load = {16'd0, w_shift[15:0]};
            default:  w_load = w_shift;
        endcase
    end

    assign wb_data = r_is_load ? w_load : r_alu_res;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage
//  Description : Self-checking bench for mem_stage with a byte-array model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] alu_res;
    logic [31:0] store_data;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [4:0]  rd_in;
    logic        reg_write_in;
    logic        bubble_in;
    logic        stall;
    logic [31:0] wb_data;
    logic [4:0]  rd_out;
    logic        reg_write_out;
    logic        valid_out;
    logic        misaligned;

    mem_stage #(.DEPTH_WORDS(1024)) dut (
        .clk          (clk),
        .rst          (rst),
        .alu_res      (alu_res),
        .store_data   (store_data),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .funct3       (funct3),
        .rd_in        (rd_in),
        .reg_write_in (reg_write_in),
        .bubble_in    (bubble_in),
        .stall        (stall),
        .wb_data      (wb_data),
        .rd_out       (rd_out),
        .reg_write_out(reg_write_out),
        .valid_out    (valid_out),
        .misaligned   (misaligned)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Byte-addressed model of the 4 KiB address space, with a written-flag.
    logic [7:0]  mdl   [4096];
    bit          known [4096];

    // Expected registered outputs.
    logic [31:0] e_wb;
    logic [4:0]  e_rd;
    logic        e_rw;
    logic        e_valid;
    logic        e_mis;
    bit          e_chkwb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".valid"}, {31'd0, valid_out},     {31'd0, e_valid});
        chk({tag, ".rd"},    {27'd0, rd_out},        {27'd0, e_rd});
        chk({tag, ".rw"},    {31'd0, reg_write_out}, {31'd0, e_rw});
        chk({tag, ".mis"},   {31'd0, misaligned},    {31'd0, e_mis});
        if (e_chkwb) chk({tag, ".wb"}, wb_data, e_wb);
    endtask

    // One pipeline slot: drive, predict from the model, clock, compare.
    task automatic op(input bit ld, input bit st, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] sd,
                      input logic [4:0] rd, input bit rw, input bit bub,
                      input bit stl, input string tag);
        int          size;
        int          idx;
        bit          mis;
        bit          allk;
        longint      v;
        logic [31:0] t;
        mem_read     = ld;
        mem_write    = st;
        funct3       = f3;
        alu_res      = a;
        store_data   = sd;
        rd_in        = rd;
        reg_write_in = rw;
        bubble_in    = bub;
        stall        = stl;
        if (!stl) begin
            size    = (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
            mis     = (ld || st) && ((a % size) != 0);
            e_valid = !bub;
            e_rd    = bub ? 5'd0 : rd;
            e_rw    = rw && !bub && !mis;
            e_mis   = mis && !bub;
            e_chkwb = 1'b0;
            if (st) begin
                if (!bub && !mis) begin
                    for (int i = 0; i < size; i++) begin
                        idx        = int'((a + 32'(i)) & 32'hFFF);
                        t          = sd >> (8 * i);
                        mdl[idx]   = t[7:0];
                        known[idx] = 1'b1;
                    end
                end
            end else if (ld) begin
                if (!bub && !mis) begin
                    v    = 0;
                    allk = 1'b1;
                    for (int i = 0; i < size; i++) begin
                        idx  = int'((a + 32'(i)) & 32'hFFF);
                        v    = v + (longint'(mdl[idx]) << (8 * i));
                        allk = allk && known[idx];
                    end
                    if (!f3[2] && size < 4 && v >= (longint'(1) << (8 * size - 1)))
                        v = v - (longint'(1) << (8 * size));
                    e_wb    = v[31:0];
                    e_chkwb = allk;
                end
            end else if (!bub) begin
                e_wb    = a;
                e_chkwb = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    logic [2:0] ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mdl[i]   = 8'd0;
            known[i] = 1'b0;
        end
        rst = 1'b1; alu_res = 0; store_data = 0; mem_read = 0; mem_write = 0;
        funct3 = 0; rd_in = 0; reg_write_in = 0; bubble_in = 0; stall = 0;
        e_wb = 0; e_rd = 0; e_rw = 0; e_valid = 0; e_mis = 0; e_chkwb = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Word round trip.
        op(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 5'd3, 0, 0, 0, "sw10");
        op(1, 0, 3'b010, 32'h10, 32'h0,        5'd7, 1, 0, 0, "lw10");
        chk("lw10.const", wb_data, 32'hDEADBEEF);

        // Byte and half extraction.
        op(0, 1, 3'b010, 32'h20, 32'h80FF7F01, 5'd0, 0, 0, 0, "sw20");
        op(1, 0, 3'b000, 32'h23, 32'h0, 5'd1, 1, 0, 0, "lb23");
        chk("lb23.const", wb_data, 32'hFFFFFF80);
        op(1, 0, 3'b100, 32'h21, 32'h0, 5'd2, 1, 0, 0, "lbu21");
        chk("lbu21.const", wb_data, 32'h0000007F);
        op(1, 0, 3'b001, 32'h22, 32'h0, 5'd3, 1, 0, 0, "lh22");
        chk("lh22.const", wb_data, 32'hFFFF80FF);
        op(1, 0, 3'b101, 32'h20, 32'h0, 5'd4, 1, 0, 0, "lhu20");
        chk("lhu20.const", wb_data, 32'h00007F01);

        // Partial stores.
        op(0, 1, 3'b010, 32'h30, 32'h11223344, 5'd0, 0, 0, 0, "sw30");
        op(0, 1, 3'b000, 32'h31, 32'h000000AA, 5'd0, 0, 0, 0, "sb31");
        op(0, 1, 3'b001, 32'h32, 32'h0000BEEF, 5'd0, 0, 0, 0, "sh32");
        op(1, 0, 3'b010, 32'h30, 32'h0, 5'd5, 1, 0, 0, "lw30");
        chk("lw30.const", wb_data, 32'hBEEFAA44);

        // Stall for three cycles with a store attempt; outputs frozen.
        op(0, 1, 3'b010, 32'h30, 32'h0, 5'd9, 1, 0, 1, "stall1");
        op(0, 1, 3'b010, 32'h30, 32'h0, 5'd9, 1, 0, 1, "stall2");
        op(1, 0, 3'b000, 32'h31, 32'h0, 5'd9, 1, 0, 1, "stall3");
        op(1, 0, 3'b010, 32'h30, 32'h0, 5'd6, 1, 0, 0, "lw30b");

        // Misalignment.
        op(0, 1, 3'b010, 32'h40, 32'h0BADF00D, 5'd0, 0, 0, 0, "sw40");
        op(0, 1, 3'b010, 32'h42, 32'hFFFFFFFF, 5'd8, 1, 0, 0, "sw42mis");
        op(1, 0, 3'b001, 32'h41, 32'h0, 5'd8, 1, 0, 0, "lh41mis");
        op(1, 0, 3'b010, 32'h40, 32'h0, 5'd8, 1, 0, 0, "lw40");

        // Bubble.
        op(0, 1, 3'b010, 32'h50, 32'h01020304, 5'd0, 0, 0, 0, "sw50");
        op(0, 1, 3'b010, 32'h50, 32'h00000055, 5'd4, 1, 1, 0, "sw50bub");
        op(1, 0, 3'b010, 32'h50, 32'h0, 5'd10, 1, 0, 0, "lw50");

        // Asynchronous reset mid-sequence; a store presented during reset is dropped.
        op(0, 1, 3'b010, 32'h60, 32'hCAFEF00D, 5'd0, 0, 0, 0, "sw60");
        op(0, 0, 3'b000, 32'h1234, 32'h0, 5'd11, 1, 0, 0, "nonmem");
        rst        = 1'b1;
        mem_write  = 1'b1;
        mem_read   = 1'b0;
        funct3     = 3'b010;
        alu_res    = 32'h60;
        store_data = 32'hFFFFFFFF;
        #2;
        e_wb = 0; e_rd = 0; e_rw = 0; e_valid = 0; e_mis = 0; e_chkwb = 1'b1;
        check_outputs("async_rst");
        @(posedge clk);
        #1;
        check_outputs("rst_hold");
        @(negedge clk);
        rst = 1'b0;
        op(1, 0, 3'b010, 32'h60, 32'h0, 5'd12, 1, 0, 0, "lw60");

        // Address wrap and pass-through value.
        op(0, 1, 3'b010, 32'h1000, 32'h12345678, 5'd0, 0, 0, 0, "sw1000");
        op(1, 0, 3'b010, 32'h0000, 32'h0, 5'd13, 1, 0, 0, "lw0");
        chk("lw0.const", wb_data, 32'h12345678);
        op(0, 0, 3'b000, 32'h7, 32'h0, 5'd14, 1, 0, 0, "alu7");
        chk("alu7.const", wb_data, 32'h7);

        // Randomized traffic over a 64-byte window.
        for (int w = 0; w < 16; w++)
            op(0, 1, 3'b010, 32'h100 + 32'(4 * w), $urandom, 5'd0, 0, 0, 0, "fill");
        for (int n = 0; n < 300; n++) begin
            int          kind;
            logic [2:0]  f3;
            logic [31:0] a;
            kind = int'($urandom_range(0, 2));
            a    = 32'h100 + 32'($urandom_range(0, 63));
            case (kind)
                0:       f3 = ld_f3[$urandom_range(0, 4)];
                1:       f3 = 3'($urandom_range(0, 2));
                default: f3 = 3'($urandom_range(0, 7));
            endcase
            op(kind == 0, kind == 1, f3, a, $urandom, 5'($urandom_range(0, 31)),
               1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0,
               $urandom_range(0, 9) == 0, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
